// File: rtl/word_pkg.sv
// Shared types for the word-period tracker.
//   word_t       : one 8-bit generator word
//   per_state_t  : period-search state (IDLE, SEARCH, DONE)
//   sig_step()   : one step of the rotate-xor period signature
package word_pkg;

    typedef logic [7:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } per_state_t;

    function automatic word_t sig_step(input word_t s, input word_t w);
        return {s[6:0], s[7]} ^ w;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with a registered head word.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   wr_data, wr_en : push request; accepted when not full, or when full and a
//                    pop happens in the same cycle
//   rd_en          : pop request; honoured only when not empty
//   head           : registered head entry (0 after reset)
//   full, empty    : occupancy flags derived from the wrap-bit pointers
module word_fifo
    import word_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  word_t wr_data,
    input  logic  wr_en,
    input  logic  rd_en,
    output word_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    word_t           mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     rd_ptr_nxt;
    logic            do_rd;
    logic            do_wr;
    word_t           head_nxt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_rd);

    // The incoming word becomes the next head only when it lands in the slot
    // the read pointer will point at (FIFO empty after this cycle's pop).
    always_comb begin
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
        if (do_wr && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            head   <= head_nxt;
        end
    end

endmodule

// File: rtl/word_period_tracker.sv
// Consumer of the word-shift generator: buffers words for a valid/ready sink,
// measures the sequence period and counts words dropped on a full FIFO.
// Optional feature macro: WORD_PERIOD_SIGNATURE_EN adds the sig output.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_word, in_valid    : generator word and its valid (never stalled)
//   out_word, out_valid  : FIFO head and non-empty flag
//   out_ready            : sink accepts head when out_valid && out_ready
//   period, period_valid : measured period, sticky valid
//   timeout              : MAX_PERIOD words seen with no recurrence, sticky
//   drop_cnt             : saturating count of words lost to a full FIFO
//   sig                  : (macro only) rotate-xor signature of one period
module word_period_tracker
    import word_pkg::*;
#(
    parameter int  DEPTH      = 4,
    parameter int  MAX_PERIOD = 255,
    parameter int  DROP_W     = 8,
    localparam int PW         = $clog2(MAX_PERIOD + 1)
) (
`ifdef WORD_PERIOD_SIGNATURE_EN
    output word_t             sig,
`endif
    input  logic              clk,
    input  logic              rst,
    input  word_t             in_word,
    input  logic              in_valid,
    output word_t             out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PW-1:0]     period,
    output logic              period_valid,
    output logic              timeout,
    output logic [DROP_W-1:0] drop_cnt
);

    logic       full;
    logic       empty;
    per_state_t state;
    word_t      ref_word;
    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_inc;
    logic       match;

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (in_word),
        .wr_en   (in_valid),
        .rd_en   (out_ready),
        .head    (out_word),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = !empty;
    assign cnt_inc   = cnt + PW'(1);
    assign match     = (in_word == ref_word);

    // A word is lost only when full and the sink is not freeing a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (in_valid && full && !(out_ready && !empty) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ref_word     <= '0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    ref_word <= in_word;
                    cnt      <= '0;
                    state    <= SEARCH;
                end
                SEARCH: begin
                    cnt <= cnt_inc;
                    if (match) begin
                        period       <= cnt_inc;
                        period_valid <= 1'b1;
                        state        <= DONE;
                    end else if (cnt_inc == PW'(MAX_PERIOD)) begin
                        timeout <= 1'b1;
                        period  <= '0;
                        state   <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WORD_PERIOD_SIGNATURE_EN
    // The recurring word closes the period and is not folded in, so the
    // signature covers exactly one period's worth of words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (in_valid && ((state == IDLE) || ((state == SEARCH) && !match))) begin
            sig <= sig_step(sig, in_word);
        end
    end
`endif

endmodule

// File: tb/tb_word_period_tracker.sv
// Bench for word_period_tracker (DEPTH=4, MAX_PERIOD=8).
// A negedge scoreboard models the FIFO and drop counter; period cases come
// from a table, multi-cycle corner cases are hand-written sequences.
module tb_word_period_tracker;

    localparam int DEPTH = 4;
    localparam int MAXP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_word = '0;
    logic       in_valid = 1'b0;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] period;
    logic       period_valid;
    logic       timeout;
    logic [7:0] drop_cnt;
`ifdef WORD_PERIOD_SIGNATURE_EN
    logic [7:0] sig;
`endif

    word_period_tracker #(.DEPTH(DEPTH), .MAX_PERIOD(MAXP), .DROP_W(8)) dut (
`ifdef WORD_PERIOD_SIGNATURE_EN
        .sig          (sig),
`endif
        .clk          (clk),
        .rst          (rst),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // FIFO scoreboard: expected words queued when driven and accepted,
    // compared against the head while present, popped when the sink reads.
    logic [7:0] q[$];
    int         exp_drop = 0;

    always @(negedge clk) begin
        logic [7:0] front;
        if (rst) begin
            q.delete();
            exp_drop = 0;
        end else begin
            chk("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("sb_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            if (q.size() != 0) begin
                front = q[0];
                chk("sb_out_word", 32'(out_word), 32'(front));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid) begin
                if (q.size() < DEPTH) q.push_back(in_word);
                else if (exp_drop < 255) exp_drop++;
            end
        end
    end

    task automatic step(input logic [7:0] w, input logic v, input logic r);
        in_word   = w;
        in_valid  = v;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(8'h00, 1'b0, 1'b1);
    endtask

    typedef struct {
        string      name;
        logic [7:0] w [6];
        int         n;
        logic [3:0] exp_period;
        logic       exp_pv;
        logic       exp_to;
        logic [7:0] exp_sig;
    } pcase_t;

    pcase_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"period3",  '{8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h00, 8'h00}, 4, 4'd3, 1'b1, 1'b0, 8'hE1};
        tbl[1] = '{"fixedpt",  '{8'hFC, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 4'd1, 1'b1, 1'b0, 8'hFC};
        tbl[2] = '{"period2",  '{8'h11, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00}, 3, 4'd2, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{"nomatch",  '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 6, 4'd0, 1'b0, 1'b0, 8'h04};
        tbl[4] = '{"period5",  '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'h77}, 6, 4'd5, 1'b1, 1'b0, 8'hBB};

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_word", 32'(out_word), 32'(0));
        chk("rst_period", 32'(period), 32'(0));
        chk("rst_period_valid", 32'(period_valid), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
`ifdef WORD_PERIOD_SIGNATURE_EN
        chk("rst_sig", 32'(sig), 32'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Period table
        for (int c = 0; c < 5; c++) begin
            do_reset();
            for (int i = 0; i < tbl[c].n; i++) begin
                if (i == tbl[c].n - 1) chk({tbl[c].name, "_pv_before"}, 32'(period_valid), 32'(0));
                step(tbl[c].w[i], 1'b1, 1'b1);
            end
            chk({tbl[c].name, "_period"}, 32'(period), 32'(tbl[c].exp_period));
            chk({tbl[c].name, "_period_valid"}, 32'(period_valid), 32'(tbl[c].exp_pv));
            chk({tbl[c].name, "_timeout"}, 32'(timeout), 32'(tbl[c].exp_to));
`ifdef WORD_PERIOD_SIGNATURE_EN
            chk({tbl[c].name, "_sig"}, 32'(sig), 32'(tbl[c].exp_sig));
`endif
            drain();
        end

        // Backpressure: 6 words into 4 slots, sink stalled
        do_reset();
        for (int i = 0; i < 6; i++) step(8'(8'h10 + i), 1'b1, 1'b0);
        chk("bp_drop_cnt", 32'(drop_cnt), 32'(2));
        chk("bp_out_valid", 32'(out_valid), 32'(1));
        chk("bp_out_word", 32'(out_word), 32'(8'h10));
        for (int i = 0; i < DEPTH; i++) step(8'h00, 1'b0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'(0));

        // Full FIFO with simultaneous read and write
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(8'(8'h20 + i), 1'b1, 1'b0);
        chk("frw_drop_before", 32'(drop_cnt), 32'(0));
        step(8'h24, 1'b1, 1'b1);
        chk("frw_drop_after", 32'(drop_cnt), 32'(0));
        chk("frw_head", 32'(out_word), 32'(8'h21));
        for (int i = 0; i < DEPTH; i++) step(8'h00, 1'b0, 1'b1);
        chk("frw_drained", 32'(out_valid), 32'(0));

        // Timeout: 9 distinct words with MAX_PERIOD=8
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("to_before", 32'(timeout), 32'(0));
            step(8'(8'h30 + i), 1'b1, 1'b1);
        end
        chk("to_timeout", 32'(timeout), 32'(1));
        chk("to_period", 32'(period), 32'(0));
        chk("to_period_valid", 32'(period_valid), 32'(0));
        step(8'h30, 1'b1, 1'b1);
        chk("to_done_hold_pv", 32'(period_valid), 32'(0));
        chk("to_done_hold_to", 32'(timeout), 32'(1));
        drain();

        // Asynchronous reset mid-SEARCH
        do_reset();
        step(8'h40, 1'b1, 1'b0);
        step(8'h41, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'(0));
        chk("mrst_out_word", 32'(out_word), 32'(0));
        chk("mrst_period_valid", 32'(period_valid), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h41, 1'b1, 1'b1);
        step(8'h42, 1'b1, 1'b1);
        step(8'h41, 1'b1, 1'b1);
        chk("mrst_period", 32'(period), 32'(2));
        chk("mrst_period_valid2", 32'(period_valid), 32'(1));
        drain();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
